// File: rtl/if_loader_pkg.sv
// if_loader_pkg: shared state encoding and default frame header for the input-feature RAM loader
package if_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CHK,
        FIN
    } state_t;

    localparam logic [7:0] HDR_DEF = 8'hA5;

endpackage

// File: rtl/if_loader.sv
// if_loader: framed byte stream to input-feature RAM writer with mod-256 checksum and idle timeout
module if_loader
    import if_loader_pkg::*;
#(
    parameter int         N_PIX   = 784,
    parameter int         ADDR_W  = 10,
    parameter logic [7:0] HDR     = HDR_DEF,
    parameter int         TIMEOUT = 50_000_000
) (
    input  logic              CK,
    input  logic              RB,
    input  logic              RX_VALID_I,
    input  logic [7:0]        RX_DATA_I,
    output logic              RX_READY_O,
    input  logic              CLR_I,
    output logic [ADDR_W-1:0] RAM_IF_ADDR_O,
    output logic [7:0]        RAM_IF_DATA_O,
    output logic              RAM_IF_WREN_O,
    output logic              BUSY_O,
    output logic              DONE_O,
    output logic              ERR_O
);

    localparam int                TW     = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(N_PIX - 1);
    localparam logic [TW-1:0]     T_LAST = TW'(TIMEOUT - 1);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [7:0]        sum;
    logic [TW-1:0]     timer;
    logic              acc;

    assign acc = RX_VALID_I && RX_READY_O;

    // frame FSM with registered write port; the timer fires on the idle edge that would bring it to TIMEOUT
    always_ff @(posedge CK or negedge RB) begin
        if (!RB) begin
            state         <= IDLE;
            cnt           <= '0;
            sum           <= '0;
            timer         <= '0;
            RX_READY_O    <= 1'b0;
            RAM_IF_ADDR_O <= '0;
            RAM_IF_DATA_O <= '0;
            RAM_IF_WREN_O <= 1'b0;
            BUSY_O        <= 1'b0;
            DONE_O        <= 1'b0;
            ERR_O         <= 1'b0;
        end else begin
            RAM_IF_WREN_O <= 1'b0;
            DONE_O        <= 1'b0;
            if (CLR_I) begin
                state      <= IDLE;
                ERR_O      <= 1'b0;
                BUSY_O     <= 1'b0;
                RX_READY_O <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        RX_READY_O <= 1'b1;
                        if (acc && RX_DATA_I == HDR) begin
                            state  <= LOAD;
                            cnt    <= '0;
                            sum    <= '0;
                            timer  <= '0;
                            ERR_O  <= 1'b0;
                            BUSY_O <= 1'b1;
                        end
                    end
                    LOAD, CHK: begin
                        if (acc) begin
                            timer <= '0;
                            if (state == LOAD) begin
                                RAM_IF_ADDR_O <= cnt;
                                RAM_IF_DATA_O <= RX_DATA_I;
                                RAM_IF_WREN_O <= 1'b1;
                                sum           <= sum + RX_DATA_I;
                                cnt           <= cnt + 1'b1;
                                if (cnt == LAST) state <= CHK;
                            end else if (RX_DATA_I == sum) begin
                                state      <= FIN;
                                DONE_O     <= 1'b1;
                                RX_READY_O <= 1'b0;
                                BUSY_O     <= 1'b0;
                            end else begin
                                state  <= IDLE;
                                ERR_O  <= 1'b1;
                                BUSY_O <= 1'b0;
                            end
                        end else if (timer == T_LAST) begin
                            state  <= IDLE;
                            ERR_O  <= 1'b1;
                            BUSY_O <= 1'b0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    FIN: begin
                        state      <= IDLE;
                        RX_READY_O <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_loader.sv
// tb_if_loader: randomized and directed frame checks against a transaction-level write/done/err model
module tb_if_loader;
    localparam int N_PIX   = 4;
    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 16;

    logic              CK = 1'b0;
    logic              RB = 1'b0;
    logic              RX_VALID_I = 1'b0;
    logic [7:0]        RX_DATA_I = 8'h00;
    logic              RX_READY_O;
    logic              CLR_I = 1'b0;
    logic [ADDR_W-1:0] RAM_IF_ADDR_O;
    logic [7:0]        RAM_IF_DATA_O;
    logic              RAM_IF_WREN_O;
    logic              BUSY_O;
    logic              DONE_O;
    logic              ERR_O;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    logic [17:0] got_q[$];
    logic [17:0] exp_q[$];

    if_loader #(.N_PIX(N_PIX), .ADDR_W(ADDR_W), .HDR(8'hA5), .TIMEOUT(TIMEOUT)) dut (
        .CK(CK), .RB(RB), .RX_VALID_I(RX_VALID_I), .RX_DATA_I(RX_DATA_I), .RX_READY_O(RX_READY_O),
        .CLR_I(CLR_I), .RAM_IF_ADDR_O(RAM_IF_ADDR_O), .RAM_IF_DATA_O(RAM_IF_DATA_O),
        .RAM_IF_WREN_O(RAM_IF_WREN_O), .BUSY_O(BUSY_O), .DONE_O(DONE_O), .ERR_O(ERR_O)
    );

    always #5 CK = ~CK;

    always @(negedge CK) begin
        if (RAM_IF_WREN_O) got_q.push_back({RAM_IF_ADDR_O, RAM_IF_DATA_O});
        if (DONE_O) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        RX_VALID_I = 1'b1;
        RX_DATA_I  = b;
        while (!RX_READY_O && n < 20) begin
            @(negedge CK);
            n++;
        end
        if (n == 20) check("ready_wait", 0, 1);
        @(negedge CK);
        RX_VALID_I = 1'b0;
    endtask

    task automatic compare_frame(input string tag, input int exp_done, input logic exp_err);
        repeat (2) @(negedge CK);
        check({tag, " nwr"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check({tag, " wr"}, 32'(got_q[i]), 32'(exp_q[i]));
        check({tag, " done"}, done_cnt, exp_done);
        check({tag, " err"}, 32'(ERR_O), 32'(exp_err));
        check({tag, " busy"}, 32'(BUSY_O), 0);
        got_q.delete();
        exp_q.delete();
        done_cnt = 0;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] pix [N_PIX], input logic [7:0] ck,
                             input int garb, input int gmax);
        int s = 0;
        logic [7:0] g;
        for (int i = 0; i < garb; i++) begin
            do g = 8'($urandom); while (g == 8'hA5);
            send(g);
        end
        send(8'hA5);
        for (int i = 0; i < N_PIX; i++) begin
            repeat ($urandom_range(0, gmax)) @(negedge CK);
            send(pix[i]);
            exp_q.push_back({10'(i), pix[i]});
            s += pix[i];
        end
        send(ck);
        compare_frame(tag, (s % 256 == ck) ? 1 : 0, (s % 256 == ck) ? 1'b0 : 1'b1);
    endtask

    initial begin
        logic [7:0] p [N_PIX];
        repeat (2) @(negedge CK);
        check("rst ready", 32'(RX_READY_O), 0);
        check("rst outs", {RAM_IF_ADDR_O, RAM_IF_DATA_O, RAM_IF_WREN_O, BUSY_O, DONE_O, ERR_O}, 0);
        RB = 1'b1;
        @(negedge CK);
        check("ready after rst", 32'(RX_READY_O), 1);

        p = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_frame("basic", p, 8'h0A, 0, 0);
        run_frame("badck", p, 8'h0B, 0, 0);
        send(8'hA5);
        check("hdr clears err", 32'(ERR_O), 0);
        for (int i = 0; i < N_PIX; i++) begin
            send(p[i]);
            exp_q.push_back({10'(i), p[i]});
        end
        send(8'h0A);
        compare_frame("recover", 1, 1'b0);
        run_frame("garbage", p, 8'h0A, 3, 0);
        p = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run_frame("wrap", p, 8'hFC, 0, 0);

        send(8'hA5);
        send(8'h01);
        exp_q.push_back({10'd0, 8'h01});
        repeat (TIMEOUT - 1) @(negedge CK);
        check("to before", 32'(ERR_O), 0);
        @(negedge CK);
        check("to err", 32'(ERR_O), 1);
        send(8'h02);
        compare_frame("timeout", 0, 1'b1);
        CLR_I = 1'b1;
        @(negedge CK);
        CLR_I = 1'b0;
        check("clr err", 32'(ERR_O), 0);

        send(8'hA5);
        send(8'h11);
        send(8'h22);
        exp_q.push_back({10'd0, 8'h11});
        exp_q.push_back({10'd1, 8'h22});
        RX_VALID_I = 1'b1;
        RX_DATA_I  = 8'h33;
        CLR_I      = 1'b1;
        @(negedge CK);
        RX_VALID_I = 1'b0;
        CLR_I      = 1'b0;
        compare_frame("clr", 0, 1'b0);

        send(8'hA5);
        send(8'h44);
        exp_q.push_back({10'd0, 8'h44});
        #2 RB = 1'b0;
        #1;
        check("arst wren", 32'(RAM_IF_WREN_O), 0);
        check("arst outs", {RX_READY_O, RAM_IF_ADDR_O, RAM_IF_DATA_O, BUSY_O, DONE_O, ERR_O}, 0);
        @(negedge CK);
        RB = 1'b1;
        @(negedge CK);
        compare_frame("arst", 0, 1'b0);

        for (int f = 0; f < 20; f++) begin
            int s = 0;
            logic [7:0] ck;
            for (int i = 0; i < N_PIX; i++) begin
                p[i] = 8'($urandom);
                s += p[i];
            end
            ck = ($urandom_range(0, 9) < 3) ? 8'(s + $urandom_range(1, 255)) : 8'(s);
            run_frame("rand", p, ck, $urandom_range(0, 3), 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end
endmodule
